pll_phase_ctrl: RTL and testbench

Supervisory controller for the ECP5 EHXPLLL that generates the LVDS panel clocks, running in the PLL reference-clock domain. It sequences PLL reset and lock qualification and drives a qualified system reset. It re-locks automatically on lock loss or lock timeout. It serves handshaked dynamic phase-shift requests on up to four PLL outputs through the PHASESEL/PHASEDIR/PHASESTEP pins.

---
 rtl/pll_ctrl_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 21 ++
 rtl/pll_phase_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL supervisory controller.
package pll_ctrl_pkg;

    localparam int PHASE_W = 8;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLOCK,
        S_STABLE,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP
    } state_t;

    // PHASESEL codes for the EHXPLLL outputs
    localparam logic [1:0] PSEL_CH0 = 2'd0;
    localparam logic [1:0] PSEL_CH1 = 2'd1;
    localparam logic [1:0] PSEL_CH2 = 2'd2;
    localparam logic [1:0] PSEL_CH3 = 2'd3;

    function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] pos,
                                                       input logic dir);
        return dir ? pos - PHASE_W'(1) : pos + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL lock into the reference-clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lock_raw,
    output logic lock_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            meta      <= lock_raw;
            lock_sync <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL reset/lock supervisor with handshaked dynamic phase stepping.
// Define PLL_PHASE_TRACK_EN to build the per-channel PHASE_POS accumulators.
module pll_phase_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_WAIT      = 64,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STEP_W         = 2,
    parameter int GAP_W          = 4
) (
    input  logic              CLKI,
    input  logic              RST,
    input  logic              PLL_LOCK,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_CH,
    input  logic              REQ_DIR,
    input  logic [7:0]        REQ_STEPS,
    output logic              PLL_RST,
    output logic [1:0]        PHASESEL,
    output logic              PHASEDIR,
    output logic              PHASESTEP,
    output logic              RST_OUT,
    output logic              LOCKED,
    output logic              DONE,
    output logic              ERR,
    output logic [7:0]        RELOCK_CNT,
    output logic [8*NUM_CH-1:0] PHASE_POS
);

    import pll_ctrl_pkg::*;

    localparam int CNT_W = 16;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, tcnt, tcnt_nx;
    logic [7:0]       rem, rem_nx;
    logic [1:0]       sel_nx;
    logic             dir_nx, pll_rst_nx, step_nx, ready_nx, locked_nx, done_nx, err_nx;
    logic             relock, pos_upd, pos_clr;
    logic             lock_s;
    logic             running;

    pll_lock_sync u_sync (
        .clk       (CLKI),
        .rst       (RST),
        .lock_raw  (PLL_LOCK),
        .lock_sync (lock_s)
    );

    assign running = (state == S_IDLE) || (state == S_SETUP) ||
                     (state == S_PULSE) || (state == S_GAP);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tcnt_nx    = tcnt;
        rem_nx     = rem;
        sel_nx     = PHASESEL;
        dir_nx     = PHASEDIR;
        pll_rst_nx = 1'b0;
        step_nx    = 1'b0;
        ready_nx   = 1'b0;
        locked_nx  = LOCKED;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        relock     = 1'b0;
        pos_upd    = 1'b0;
        pos_clr    = 1'b0;

        if (running && !lock_s) begin
            relock = 1'b1;
            err_nx = (state != S_IDLE);
        end else begin
            case (state)
                S_PLLRST: begin
                    pll_rst_nx = 1'b1;
                    cnt_nx     = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_nx   = S_WAITLOCK;
                        pll_rst_nx = 1'b0;
                        cnt_nx     = '0;
                        tcnt_nx    = '0;
                    end
                end
                S_WAITLOCK: begin
                    if (lock_s) begin
                        state_nx = S_STABLE;
                        cnt_nx   = CNT_W'(1);
                    end else if (tcnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        relock = 1'b1;
                    end else begin
                        tcnt_nx = tcnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    // Lock glitches restart qualification but keep eating the timeout budget
                    if (!lock_s) begin
                        cnt_nx = '0;
                        if (tcnt == CNT_W'(LOCK_TIMEOUT - 1)) relock = 1'b1;
                        else tcnt_nx = tcnt + CNT_W'(1);
                    end else if (cnt >= CNT_W'(LOCK_WAIT - 1)) begin
                        state_nx  = S_IDLE;
                        locked_nx = 1'b1;
                        ready_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    ready_nx = 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        state_nx = S_SETUP;
                        sel_nx   = REQ_CH;
                        dir_nx   = REQ_DIR;
                        rem_nx   = REQ_STEPS;
                        ready_nx = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (int'(PHASESEL) >= NUM_CH) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                        ready_nx = 1'b1;
                    end else if (rem == 8'd0) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                        ready_nx = 1'b1;
                    end else begin
                        state_nx = S_PULSE;
                        step_nx  = 1'b1;
                        cnt_nx   = '0;
                    end
                end
                S_PULSE: begin
                    if (cnt == CNT_W'(STEP_W - 1)) begin
                        state_nx = S_GAP;
                        cnt_nx   = '0;
                        pos_upd  = 1'b1;
                    end else begin
                        step_nx = 1'b1;
                        cnt_nx  = cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_W - 1)) begin
                        cnt_nx = '0;
                        rem_nx = rem - 8'd1;
                        if (rem == 8'd1) begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                            ready_nx = 1'b1;
                        end else begin
                            state_nx = S_PULSE;
                            step_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: state_nx = S_PLLRST;
            endcase
        end

        if (relock) begin
            state_nx   = S_PLLRST;
            cnt_nx     = '0;
            pll_rst_nx = 1'b1;
            locked_nx  = 1'b0;
            step_nx    = 1'b0;
            ready_nx   = 1'b0;
            pos_clr    = 1'b1;
        end
    end

    always_ff @(posedge CLKI) begin
        if (RST) begin
            state      <= S_PLLRST;
            cnt        <= '0;
            tcnt       <= '0;
            rem        <= '0;
            PLL_RST    <= 1'b1;
            RST_OUT    <= 1'b1;
            LOCKED     <= 1'b0;
            REQ_READY  <= 1'b0;
            PHASESEL   <= '0;
            PHASEDIR   <= 1'b0;
            PHASESTEP  <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            RELOCK_CNT <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tcnt       <= tcnt_nx;
            rem        <= rem_nx;
            PLL_RST    <= pll_rst_nx;
            RST_OUT    <= ~locked_nx;
            LOCKED     <= locked_nx;
            REQ_READY  <= ready_nx;
            PHASESEL   <= sel_nx;
            PHASEDIR   <= dir_nx;
            PHASESTEP  <= step_nx;
            DONE       <= done_nx;
            ERR        <= err_nx;
            if (relock && RELOCK_CNT != 8'hFF) RELOCK_CNT <= RELOCK_CNT + 8'd1;
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic [NUM_CH-1:0][PHASE_W-1:0] pos;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pos
        always_ff @(posedge CLKI) begin
            if (RST || pos_clr) pos[i] <= '0;
            else if (pos_upd && PHASESEL == 2'(i)) pos[i] <= phase_step(pos[i], PHASEDIR);
        end
    end

    assign PHASE_POS = pos;
`else
    logic unused_pos;
    assign unused_pos = pos_upd ^ pos_clr;
    assign PHASE_POS  = '0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: lock sequencing, phase requests, lock loss, timeout, reset.
module tb_pll_phase_ctrl;

    import pll_ctrl_pkg::*;

`ifdef PLL_PHASE_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       CLKI = 1'b0;
    logic       RST = 1'b1;
    logic       PLL_LOCK = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic [1:0] REQ_CH = '0;
    logic       REQ_DIR = 1'b0;
    logic [7:0] REQ_STEPS = '0;

    logic        REQ_READY, PLL_RST, PHASEDIR, PHASESTEP, RST_OUT, LOCKED, DONE, ERR;
    logic [1:0]  PHASESEL;
    logic [7:0]  RELOCK_CNT;
    logic [31:0] PHASE_POS;

    logic        b_ready, b_pll_rst, b_dir, b_step, b_rst_out, b_locked, b_done, b_err;
    logic [1:0]  b_sel;
    logic [7:0]  b_relock;
    logic [15:0] b_pos;

    logic        c_ready, c_pll_rst, c_dir, c_step, c_rst_out, c_locked, c_done, c_err;
    logic [1:0]  c_sel;
    logic [7:0]  c_relock;
    logic [31:0] c_pos;

    int checks = 0;
    int failures = 0;
    logic [31:0] st, dn, rd, er, bs;

    always #5 CLKI = ~CLKI;

    pll_phase_ctrl u_dut (
        .CLKI(CLKI), .RST(RST), .PLL_LOCK(PLL_LOCK),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CH(REQ_CH),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .PLL_RST(PLL_RST), .PHASESEL(PHASESEL), .PHASEDIR(PHASEDIR), .PHASESTEP(PHASESTEP),
        .RST_OUT(RST_OUT), .LOCKED(LOCKED), .DONE(DONE), .ERR(ERR),
        .RELOCK_CNT(RELOCK_CNT), .PHASE_POS(PHASE_POS)
    );

    pll_phase_ctrl #(.NUM_CH(2)) u_dut2 (
        .CLKI(CLKI), .RST(RST), .PLL_LOCK(PLL_LOCK),
        .REQ_VALID(REQ_VALID), .REQ_READY(b_ready), .REQ_CH(REQ_CH),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .PLL_RST(b_pll_rst), .PHASESEL(b_sel), .PHASEDIR(b_dir), .PHASESTEP(b_step),
        .RST_OUT(b_rst_out), .LOCKED(b_locked), .DONE(b_done), .ERR(b_err),
        .RELOCK_CNT(b_relock), .PHASE_POS(b_pos)
    );

    // Short-timing instance so the relock counter can saturate within a short run
    pll_phase_ctrl #(.PLL_RST_CYCLES(2), .LOCK_WAIT(4), .LOCK_TIMEOUT(4)) u_dut3 (
        .CLKI(CLKI), .RST(RST), .PLL_LOCK(PLL_LOCK),
        .REQ_VALID(REQ_VALID), .REQ_READY(c_ready), .REQ_CH(REQ_CH),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .PLL_RST(c_pll_rst), .PHASESEL(c_sel), .PHASEDIR(c_dir), .PHASESTEP(c_step),
        .RST_OUT(c_rst_out), .LOCKED(c_locked), .DONE(c_done), .ERR(c_err),
        .RELOCK_CNT(c_relock), .PHASE_POS(c_pos)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLKI);
        #1;
    endtask

    function automatic logic [31:0] xpos(input logic [31:0] v);
        return TRACK ? v : 32'd0;
    endfunction

    // Presents one request for exactly one edge (the accept edge)
    task automatic req(input logic [1:0] ch, input logic dir, input logic [7:0] steps);
        REQ_CH    = ch;
        REQ_DIR   = dir;
        REQ_STEPS = steps;
        REQ_VALID = 1'b1;
        tick(1);
        REQ_VALID = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_pll_rst"}, 32'(PLL_RST), 32'd1);
        chk({p, "_rst_out"}, 32'(RST_OUT), 32'd1);
        chk({p, "_locked"}, 32'(LOCKED), 32'd0);
        chk({p, "_ready"}, 32'(REQ_READY), 32'd0);
        chk({p, "_sel"}, 32'(PHASESEL), 32'd0);
        chk({p, "_dir"}, 32'(PHASEDIR), 32'd0);
        chk({p, "_step"}, 32'(PHASESTEP), 32'd0);
        chk({p, "_done"}, 32'(DONE), 32'd0);
        chk({p, "_err"}, 32'(ERR), 32'd0);
        chk({p, "_relock"}, 32'(RELOCK_CNT), 32'd0);
        chk({p, "_pos"}, PHASE_POS, 32'd0);
    endtask

    initial begin
        // Reset and lock qualification
        tick(3);
        chk_reset("rst0");
        RST = 1'b0;
        tick(15);
        chk("pllrst_e15", 32'(PLL_RST), 32'd1);
        tick(1);
        chk("pllrst_e16", 32'(PLL_RST), 32'd0);
        tick(63);
        chk("locked_e79", 32'(LOCKED), 32'd0);
        chk("rst_out_e79", 32'(RST_OUT), 32'd1);
        tick(1);
        chk("locked_e80", 32'(LOCKED), 32'd1);
        chk("rst_out_e80", 32'(RST_OUT), 32'd0);
        chk("ready_e80", 32'(REQ_READY), 32'd1);
        chk("relock_e80", 32'(RELOCK_CNT), 32'd0);

        // CH2 +3 steps; NUM_CH=2 instance rejects CH2
        req(PSEL_CH2, 1'b0, 8'd3);
        chk("ready_drop", 32'(REQ_READY), 32'd0);
        st = '0; dn = '0; rd = '0; er = '0; bs = '0;
        for (int k = 1; k <= 19; k++) begin
            tick(1);
            if (k == 1) begin
                chk("sel_ch2", 32'(PHASESEL), 32'd2);
                chk("dir_ch2", 32'(PHASEDIR), 32'd0);
            end
            st[k-1] = PHASESTEP; dn[k-1] = DONE; rd[k-1] = REQ_READY;
            er[k-1] = ERR; bs[k-1] = b_err;
        end
        chk("r2_step_seq", st, 32'h0000_30C3);
        chk("r2_done_seq", dn, 32'h0004_0000);
        chk("r2_ready_seq", rd, 32'h0004_0000);
        chk("r2_err_seq", er, 32'h0);
        chk("r2_b_err_seq", bs, 32'h1);
        chk("r2_pos", PHASE_POS, xpos(32'h0003_0000));
        tick(1);
        chk("r2_done_clear", 32'(DONE), 32'd0);

        // CH3 on both: main steps once, NUM_CH=2 instance errors with no pulse
        req(PSEL_CH3, 1'b0, 8'd1);
        st = '0; dn = '0; er = '0; bs = '0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            st[k-1] = PHASESTEP; dn[k-1] = DONE; er[k-1] = b_err; bs[k-1] = b_step;
        end
        chk("r3_step_seq", st, 32'h3);
        chk("r3_done_seq", dn, 32'h40);
        chk("r3_b_err_seq", er, 32'h1);
        chk("r3_b_step_seq", bs, 32'h0);
        chk("r3_b_ready", 32'(b_ready), 32'd1);
        chk("r3_pos", PHASE_POS, xpos(32'h0103_0000));

        // Zero-step request completes with no pulse
        req(PSEL_CH0, 1'b0, 8'd0);
        st = '0; dn = '0; rd = '0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            st[k-1] = PHASESTEP; dn[k-1] = DONE; rd[k-1] = REQ_READY;
        end
        chk("r4_step_seq", st, 32'h0);
        chk("r4_done_seq", dn, 32'h1);
        chk("r4_ready_seq", rd, 32'h7);

        // Lock lost during the second pulse
        req(PSEL_CH2, 1'b0, 8'd3);
        tick(6);
        PLL_LOCK = 1'b0;
        tick(2);
        chk("ll_step_a8", 32'(PHASESTEP), 32'd1);
        chk("ll_err_a8", 32'(ERR), 32'd0);
        chk("ll_pos_a8", PHASE_POS, xpos(32'h0104_0000));
        tick(1);
        chk("ll_step", 32'(PHASESTEP), 32'd0);
        chk("ll_err", 32'(ERR), 32'd1);
        chk("ll_locked", 32'(LOCKED), 32'd0);
        chk("ll_rst_out", 32'(RST_OUT), 32'd1);
        chk("ll_pll_rst", 32'(PLL_RST), 32'd1);
        chk("ll_relock", 32'(RELOCK_CNT), 32'd1);
        chk("ll_pos", PHASE_POS, 32'd0);
        chk("ll_ready", 32'(REQ_READY), 32'd0);
        chk("ll_b_err_idle", 32'(b_err), 32'd0);
        chk("ll_b_relock", 32'(b_relock), 32'd1);
        tick(1);
        chk("ll_err_clear", 32'(ERR), 32'd0);
        tick(14);
        chk("ll_pll_rst_16", 32'(PLL_RST), 32'd1);
        tick(1);
        chk("ll_pll_rst_17", 32'(PLL_RST), 32'd0);

        // Lock held low: timeout re-reset after 16+1024 cycles
        tick(1023);
        chk("to_pll_rst_pre", 32'(PLL_RST), 32'd0);
        chk("to_relock_pre", 32'(RELOCK_CNT), 32'd1);
        tick(1);
        chk("to_pll_rst", 32'(PLL_RST), 32'd1);
        chk("to_relock", 32'(RELOCK_CNT), 32'd2);
        tick(1000);
        chk("sat_relock_a", 32'(c_relock), 32'd255);
        tick(30);
        chk("sat_relock_b", 32'(c_relock), 32'd255);

        // Fresh lock, decrement wrap, then reset mid-GAP
        PLL_LOCK = 1'b1;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(80);
        chk("relock_locked", 32'(LOCKED), 32'd1);
        chk("relock_cleared", 32'(RELOCK_CNT), 32'd0);
        req(PSEL_CH1, 1'b1, 8'd1);
        tick(7);
        chk("wrap_done", 32'(DONE), 32'd1);
        chk("wrap_dir", 32'(PHASEDIR), 32'd1);
        chk("wrap_pos", PHASE_POS, xpos(32'h0000_FF00));
        req(PSEL_CH1, 1'b1, 8'd2);
        tick(3);
        chk("gap_step", 32'(PHASESTEP), 32'd0);
        chk("gap_pos", PHASE_POS, xpos(32'h0000_FE00));
        RST = 1'b1;
        tick(1);
        chk_reset("midgap");
        dn = '0;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) RST = 1'b0;
            tick(1);
            dn[k] = DONE | ERR;
        end
        chk("midgap_no_done", dn, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
